// File: rtl/norm_pkg.sv
// Shared types and defaults for the normalizer receive path.
package norm_pkg;

  localparam int unsigned NORM_COL   = 8;
  localparam int unsigned NORM_W_OUT = 16;

  typedef logic [NORM_COL-1:0][NORM_W_OUT-1:0] norm_vec_t;

  typedef enum logic [1:0] {
    IDLE,
    FILL,
    DROP
  } coll_state_e;

endpackage

// File: rtl/norm_pingpong_buf.sv
// Two-entry vector store: element-wise write side, registered valid/ready read side.
module norm_pingpong_buf #(
  parameter int unsigned COL   = norm_pkg::NORM_COL,
  parameter int unsigned W_OUT = norm_pkg::NORM_W_OUT,
  localparam int unsigned IDX_W = (COL > 1) ? $clog2(COL) : 1
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      wr_en,
  input  logic [IDX_W-1:0]          wr_idx,
  input  logic [W_OUT-1:0]          wr_data_1,
  input  logic [W_OUT-1:0]          wr_data_2,
  input  logic                      wr_commit,
  output logic                      wr_full,
  output logic                      rd_valid,
  output logic [COL-1:0][W_OUT-1:0] rd_data_1,
  output logic [COL-1:0][W_OUT-1:0] rd_data_2,
  input  logic                      rd_ready
);

  typedef logic [COL-1:0][W_OUT-1:0] vec_t;

  vec_t [1:0] mem1_q, mem1_d;
  vec_t [1:0] mem2_q, mem2_d;
  logic [1:0] full_q, full_d;
  logic [1:0] full_left;
  logic       wr_ptr_q, wr_ptr_d;
  logic       rd_ptr_q, rd_ptr_d;
  logic       valid_q, valid_d;
  vec_t       data1_q, data1_d;
  vec_t       data2_q, data2_d;
  logic       consume;

  always_comb begin
    mem1_d = mem1_q;
    mem2_d = mem2_q;
    if (wr_en) begin
      mem1_d[wr_ptr_q][wr_idx] = wr_data_1;
      mem2_d[wr_ptr_q][wr_idx] = wr_data_2;
    end

    consume   = valid_q && rd_ready;
    full_left = full_q;
    rd_ptr_d  = rd_ptr_q;
    if (consume) begin
      full_left[rd_ptr_q] = 1'b0;
      rd_ptr_d            = ~rd_ptr_q;
    end

    full_d   = full_left;
    wr_ptr_d = wr_ptr_q;
    if (wr_commit) begin
      full_d[wr_ptr_q] = 1'b1;
      wr_ptr_d         = ~wr_ptr_q;
    end

    // Output view ignores this cycle's commit, giving one cycle of commit-to-valid
    // latency while still letting a held second vector follow a consume with no bubble.
    valid_d = full_left[rd_ptr_d];
    data1_d = data1_q;
    data2_d = data2_q;
    if (valid_d) begin
      data1_d = mem1_q[rd_ptr_d];
      data2_d = mem2_q[rd_ptr_d];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      mem1_q   <= '0;
      mem2_q   <= '0;
      full_q   <= '0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      valid_q  <= 1'b0;
      data1_q  <= '0;
      data2_q  <= '0;
    end else begin
      mem1_q   <= mem1_d;
      mem2_q   <= mem2_d;
      full_q   <= full_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      valid_q  <= valid_d;
      data1_q  <= data1_d;
      data2_q  <= data2_d;
    end
  end

  assign wr_full   = full_q[wr_ptr_q];
  assign rd_valid  = valid_q;
  assign rd_data_1 = data1_q;
  assign rd_data_2 = data2_q;

endmodule

// File: rtl/norm_collector.sv
// Reassembles the two serial normalizer streams into COL-wide vectors, double-buffered.
module norm_collector
  import norm_pkg::*;
#(
  parameter int unsigned COL   = NORM_COL,
  parameter int unsigned W_OUT = NORM_W_OUT
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 norm_valid,
  input  logic [W_OUT-1:0]     psum_norm_1,
  input  logic [W_OUT-1:0]     psum_norm_2,
  output logic [COL*W_OUT-1:0] m_data_1,
  output logic [COL*W_OUT-1:0] m_data_2,
  output logic                 m_valid,
  input  logic                 m_ready,
  output logic                 err_short,
  output logic                 err_overflow,
  output logic [15:0]          burst_cnt
);

  localparam int unsigned IDX_W = (COL > 1) ? $clog2(COL) : 1;

  coll_state_e              state_q, state_d;
  logic [IDX_W-1:0]         idx_q, idx_d;
  logic                     err_short_q, err_short_d;
  logic                     err_overflow_q, err_overflow_d;
  logic [15:0]              burst_cnt_q, burst_cnt_d;
  logic                     wr_en;
  logic                     wr_commit;
  logic                     wr_full;
  logic [COL-1:0][W_OUT-1:0] rd_data_1;
  logic [COL-1:0][W_OUT-1:0] rd_data_2;

  always_comb begin
    state_d        = state_q;
    idx_d          = idx_q;
    err_short_d    = 1'b0;
    err_overflow_d = err_overflow_q;
    burst_cnt_d    = burst_cnt_q;
    wr_en          = 1'b0;
    wr_commit      = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (norm_valid) begin
          if (!wr_full) begin
            wr_en   = 1'b1;
            idx_d   = IDX_W'(1);
            state_d = FILL;
          end else begin
            err_overflow_d = 1'b1;
            state_d        = DROP;
          end
        end
      end
      FILL: begin
        if (norm_valid) begin
          wr_en = 1'b1;
          if (idx_q == IDX_W'(COL - 1)) begin
            wr_commit   = 1'b1;
            burst_cnt_d = burst_cnt_q + 16'd1;
            idx_d       = '0;
            state_d     = IDLE;
          end else begin
            idx_d = idx_q + IDX_W'(1);
          end
        end else begin
          err_short_d = 1'b1;
          idx_d       = '0;
          state_d     = IDLE;
        end
      end
      DROP: begin
        if (!norm_valid) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= IDLE;
      idx_q          <= '0;
      err_short_q    <= 1'b0;
      err_overflow_q <= 1'b0;
      burst_cnt_q    <= '0;
    end else begin
      state_q        <= state_d;
      idx_q          <= idx_d;
      err_short_q    <= err_short_d;
      err_overflow_q <= err_overflow_d;
      burst_cnt_q    <= burst_cnt_d;
    end
  end

  norm_pingpong_buf #(
    .COL   (COL),
    .W_OUT (W_OUT)
  ) u_buf (
    .clk       (clk),
    .reset     (reset),
    .wr_en     (wr_en),
    .wr_idx    (idx_q),
    .wr_data_1 (psum_norm_1),
    .wr_data_2 (psum_norm_2),
    .wr_commit (wr_commit),
    .wr_full   (wr_full),
    .rd_valid  (m_valid),
    .rd_data_1 (rd_data_1),
    .rd_data_2 (rd_data_2),
    .rd_ready  (m_ready)
  );

  assign m_data_1     = rd_data_1;
  assign m_data_2     = rd_data_2;
  assign err_short    = err_short_q;
  assign err_overflow = err_overflow_q;
  assign burst_cnt    = burst_cnt_q;

endmodule
